// File: rtl/panel_pkg.sv
// panel_pkg: shared types and constants for the front-panel input controller.
//   panel_state_t : OFF / SELECT / RUN.
//   BTN_*         : bit index of each button in the press/grant vectors. A
//                   lower index means a higher arbitration priority.
//   MODE_W        : width of the mode output.
package panel_pkg;

   typedef enum logic [1:0] {
      OFF    = 2'd0,
      SELECT = 2'd1,
      RUN    = 2'd2
   } panel_state_t;

   localparam int NUM_BTNS  = 5;
   localparam int BTN_POWER = 0;
   localparam int BTN_START = 1;
   localparam int BTN_MODE  = 2;
   localparam int BTN_TUP   = 3;
   localparam int BTN_TDOWN = 4;

   localparam int MODE_W = 3;

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-FF synchroniser, debounce counter and rising-edge press pulse
// for a single raw push-button.
//   clk, rst_n : clock, asynchronous active-low reset
//   btn        : raw asynchronous button, active-high
//   press      : registered one-cycle pulse when the debounced level rises
// The debounced level changes once the synchronised sample has disagreed with it
// on DEBOUNCE_CYCLES consecutive edges and disagrees again on the next one.
module btn_debounce
   import panel_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   output logic press
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic [1:0]    sync;
   logic          level;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync  <= '0;
         level <= 1'b0;
         cnt   <= '0;
         press <= 1'b0;
      end else begin
         sync  <= {sync[0], btn};
         press <= 1'b0;
         if (sync[1] != level) begin
            if (cnt == CW'(DEBOUNCE_CYCLES)) begin
               level <= sync[1];
               cnt   <= '0;
               press <= sync[1];  // rises only; a release flips level silently
            end else begin
               cnt <= cnt + CW'(1);
            end
         end else begin
            cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/panel_input_ctrl.sv
// panel_input_ctrl: washing-machine front-panel controller. Debounces five
// buttons, arbitrates presses (Power > Start > Mode > TimerUp > TimerDown),
// and runs the OFF/SELECT/RUN state machine driving the core's level inputs.
//   clk, rst_n          : clock, asynchronous active-low reset
//   btnPower..btnTimerDown : raw asynchronous buttons, active-high
//   cycleComplete       : one-cycle pulse from the core at end of wash
//   powerButton, run, configu, mode, manualTimer : registered core controls
//   beep                : acknowledge pulse (only built with PANEL_BEEP_EN)
// Build option: define PANEL_BEEP_EN to build the beep counter; otherwise beep
// is tied low.
module panel_input_ctrl
   import panel_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int TIMER_STEP      = 10,
   parameter int TIMER_MAX       = 300,
   parameter int NUM_MODES       = 7,
   parameter int BEEP_CYCLES     = 50
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              btnPower,
   input  logic              btnStart,
   input  logic              btnMode,
   input  logic              btnTimerUp,
   input  logic              btnTimerDown,
   input  logic              cycleComplete,
   output logic              powerButton,
   output logic              run,
   output logic              configu,
   output logic [MODE_W-1:0] mode,
   output logic [31:0]       manualTimer,
   output logic              beep
);

   localparam int TW = $clog2(TIMER_MAX + 1);
   localparam logic [TW-1:0]     T_MAX    = TW'(TIMER_MAX);
   localparam logic [TW-1:0]     T_STEP   = TW'(TIMER_STEP);
   localparam logic [MODE_W-1:0] MODE_TOP = MODE_W'(NUM_MODES - 1);

   logic [NUM_BTNS-1:0] raw, press, grant;
   panel_state_t        state;
   logic [TW-1:0]       timer_q, timer_up, timer_dn;

   assign raw = {btnTimerDown, btnTimerUp, btnMode, btnStart, btnPower};

   for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
      btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
         .clk   (clk),
         .rst_n (rst_n),
         .btn   (raw[i]),
         .press (press[i])
      );
   end

   // Keep only the lowest set bit: lowest index is highest priority.
   assign grant = press & (~press + NUM_BTNS'(1));

   // Timer is always a multiple of the step, so these saturate exactly.
   always_comb begin
      timer_up = (timer_q >= T_MAX - T_STEP) ? T_MAX : timer_q + T_STEP;
      timer_dn = (timer_q <= T_STEP) ? '0 : timer_q - T_STEP;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= OFF;
         powerButton <= 1'b0;
         run         <= 1'b0;
         configu     <= 1'b0;
         mode        <= '0;
         timer_q     <= '0;
      end else begin
         case (state)
            OFF: begin
               if (grant[BTN_POWER]) begin
                  state       <= SELECT;
                  powerButton <= 1'b1;
               end
            end
            SELECT: begin
               if (grant[BTN_POWER]) begin
                  state       <= OFF;
                  powerButton <= 1'b0;
                  mode        <= '0;
                  timer_q     <= '0;
                  configu     <= 1'b0;
               end else if (grant[BTN_START]) begin
                  state <= RUN;
                  run   <= 1'b1;
               end else if (grant[BTN_MODE]) begin
                  mode <= (mode == MODE_TOP) ? '0 : mode + MODE_W'(1);
               end else if (grant[BTN_TUP]) begin
                  timer_q <= timer_up;
                  configu <= (timer_up != '0);
               end else if (grant[BTN_TDOWN]) begin
                  timer_q <= timer_dn;
                  configu <= (timer_dn != '0);
               end
            end
            RUN: begin
               // Mode/timer grants are dropped here: configuration is locked.
               if (grant[BTN_POWER]) begin
                  state       <= OFF;
                  powerButton <= 1'b0;
                  run         <= 1'b0;
                  mode        <= '0;
                  timer_q     <= '0;
                  configu     <= 1'b0;
               end else if (grant[BTN_START] || cycleComplete) begin
                  state <= SELECT;
                  run   <= 1'b0;
               end
            end
            default: begin
               state       <= OFF;
               powerButton <= 1'b0;
               run         <= 1'b0;
               configu     <= 1'b0;
               mode        <= '0;
               timer_q     <= '0;
            end
         endcase
      end
   end

   assign manualTimer = {{(32 - TW){1'b0}}, timer_q};

`ifdef PANEL_BEEP_EN
   localparam int BW = $clog2(BEEP_CYCLES + 1);

   logic          accept;
   logic [BW-1:0] beep_cnt;

   // A trigger is any grant the current state acts on, plus end-of-wash.
   always_comb begin
      case (state)
         OFF:     accept = grant[BTN_POWER];
         SELECT:  accept = |grant;
         RUN:     accept = grant[BTN_POWER] | grant[BTN_START] | cycleComplete;
         default: accept = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beep     <= 1'b0;
         beep_cnt <= '0;
      end else if (accept) begin
         beep     <= 1'b1;
         beep_cnt <= BW'(BEEP_CYCLES - 1);
      end else if (beep_cnt != '0) begin
         beep_cnt <= beep_cnt - BW'(1);
      end else begin
         beep <= 1'b0;
      end
   end
`else
   assign beep = 1'b0;
`endif

endmodule

// File: tb/tb_panel_input_ctrl.sv
// tb_panel_input_ctrl: directed bench for panel_input_ctrl with DEBOUNCE_CYCLES=4.
// A panel-level model is fed press events at the edge the press latency says they
// take effect; every cycle the DUT outputs are compared against it, and literal
// expectations after each step pin the model itself.
module tb_panel_input_ctrl;

   localparam int D = 4;

   logic        clk = 1'b0, rst_n = 1'b0, cc = 1'b0;
   logic [4:0]  btns = '0;
   logic        powerButton, run, configu, beep;
   logic [2:0]  mode;
   logic [31:0] manualTimer;

   panel_input_ctrl #(
      .DEBOUNCE_CYCLES (D),
      .TIMER_STEP      (10),
      .TIMER_MAX       (300),
      .NUM_MODES       (7),
      .BEEP_CYCLES     (50)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .btnPower      (btns[0]),
      .btnStart      (btns[1]),
      .btnMode       (btns[2]),
      .btnTimerUp    (btns[3]),
      .btnTimerDown  (btns[4]),
      .cycleComplete (cc),
      .powerButton   (powerButton),
      .run           (run),
      .configu       (configu),
      .mode          (mode),
      .manualTimer   (manualTimer),
      .beep          (beep)
   );

   always #5 clk = ~clk;

   int         cyc = 0, vectors = 0, misses = 0;
   logic [4:0] pend [int];          // edge number -> presses taking effect there
   int         m_st = 0;            // 0 off, 1 select, 2 run
   int         m_mode = 0, m_timer = 0, beep_until = 0;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         misses++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, got, exp);
      end
   endtask

   // Panel model, advanced on every active edge.
   always @(posedge clk) begin
      logic [4:0] p;
      bit acc;
      cyc++;
      p   = pend.exists(cyc) ? pend[cyc] : 5'd0;
      acc = 0;
      if (!rst_n) begin
         m_st = 0; m_mode = 0; m_timer = 0; beep_until = 0;
      end else begin
         case (m_st)
            0: if (p[0]) begin m_st = 1; acc = 1; end
            1: begin
               acc = (p != 0);
               if (p[0]) begin m_st = 0; m_mode = 0; m_timer = 0; end
               else if (p[1]) m_st = 2;
               else if (p[2]) m_mode = (m_mode + 1) % 7;
               else if (p[3]) m_timer = (m_timer + 10 > 300) ? 300 : m_timer + 10;
               else if (p[4]) m_timer = (m_timer < 10) ? 0 : m_timer - 10;
            end
            default: begin
               if (p[0]) begin m_st = 0; m_mode = 0; m_timer = 0; acc = 1; end
               else if (p[1] || cc) begin m_st = 1; acc = 1; end
            end
         endcase
         if (acc) beep_until = cyc + 50;
      end
   end

   // Every-cycle compare against the model.
   always @(negedge clk) begin
      chk("powerButton", {31'd0, powerButton}, (m_st != 0) ? 32'd1 : 32'd0);
      chk("run",         {31'd0, run},         (m_st == 2) ? 32'd1 : 32'd0);
      chk("configu",     {31'd0, configu},     (m_timer != 0) ? 32'd1 : 32'd0);
      chk("mode",        {29'd0, mode},        32'(m_mode));
      chk("manualTimer", manualTimer,          32'(m_timer));
`ifdef PANEL_BEEP_EN
      chk("beep",        {31'd0, beep},        (cyc < beep_until) ? 32'd1 : 32'd0);
`else
      chk("beep",        {31'd0, beep},        32'd0);
`endif
   end

   // Hold buttons m long enough for one press, release, wait for the release to settle.
   task automatic press(input logic [4:0] m);
      int n;
      @(posedge clk); #1;
      btns = m;
      n = cyc + 1;                  // edge that first samples the new level
      pend[n + 3 + D] = m;
      repeat (8) @(posedge clk); #1;
      btns = '0;
      repeat (12) @(posedge clk); #1;
   endtask

   task automatic pulse_cc();
      @(posedge clk); #1 cc = 1'b1;
      @(posedge clk); #1 cc = 1'b0;
   endtask

   initial begin
      int c0;
      logic [2:0] seq [8];
      seq = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd0, 3'd1};

      // Reset
      repeat (4) @(posedge clk); #1 rst_n = 1'b1;
      repeat (3) @(posedge clk); #1;
      chk("reset_power", {31'd0, powerButton}, 32'd0);
      chk("reset_timer", manualTimer, 32'd0);

      // 3-cycle glitch is filtered
      btns[0] = 1'b1;
      repeat (3) @(posedge clk); #1 btns[0] = 1'b0;
      repeat (12) @(posedge clk); #1;
      chk("glitch_power", {31'd0, powerButton}, 32'd0);

      // Power-on latency: first sample at c0+1, output changes 7 edges later
      @(posedge clk); #1;
      btns[0] = 1'b1; c0 = cyc; pend[c0 + 1 + 3 + D] = 5'b00001;
      repeat (7) @(posedge clk); #1;
      chk("pwr_lat_before", {31'd0, powerButton}, 32'd0);
      @(posedge clk); #1;
      chk("pwr_lat_at", {31'd0, powerButton}, 32'd1);
      repeat (2) @(posedge clk); #1 btns[0] = 1'b0;
      repeat (12) @(posedge clk); #1;

      // Mode wrap
      for (int i = 0; i < 8; i++) begin
         press(5'b00100);
         chk("mode_wrap", {29'd0, mode}, {29'd0, seq[i]});
      end

      // Second power press -> OFF, mode cleared; then back on
      press(5'b00001);
      chk("off_power", {31'd0, powerButton}, 32'd0);
      chk("off_mode", {29'd0, mode}, 32'd0);
      press(5'b00001);
      chk("on_again", {31'd0, powerButton}, 32'd1);

      // Timer saturation
      for (int i = 0; i < 32; i++) press(5'b01000);
      chk("timer_max", manualTimer, 32'd300);
      chk("timer_max_cfg", {31'd0, configu}, 32'd1);
      for (int i = 0; i < 31; i++) press(5'b10000);
      chk("timer_zero", manualTimer, 32'd0);
      chk("timer_zero_cfg", {31'd0, configu}, 32'd0);
      for (int i = 0; i < 3; i++) press(5'b01000);
      chk("timer_30", manualTimer, 32'd30);

      // cycleComplete outside RUN is ignored
      pulse_cc();
      chk("cc_select_run", {31'd0, run}, 32'd0);
      chk("cc_select_pwr", {31'd0, powerButton}, 32'd1);

      // Run lock
      press(5'b00100); press(5'b00100);
      chk("mode_pre_run", {29'd0, mode}, 32'd2);
      press(5'b00010);
      chk("run_on", {31'd0, run}, 32'd1);
      press(5'b00100);
      chk("run_mode_lock", {29'd0, mode}, 32'd2);
      press(5'b01000);
      chk("run_timer_lock", manualTimer, 32'd30);
      pulse_cc();
      chk("cc_run_off", {31'd0, run}, 32'd0);
      chk("cc_mode_kept", {29'd0, mode}, 32'd2);
      chk("cc_timer_kept", manualTimer, 32'd30);

      // Start cancels, then Power during RUN clears everything
      press(5'b00010);
      press(5'b00010);
      chk("start_cancel", {31'd0, run}, 32'd0);
      press(5'b00010);
      press(5'b00001);
      chk("run_pwr_off_pb", {31'd0, powerButton}, 32'd0);
      chk("run_pwr_off_run", {31'd0, run}, 32'd0);
      chk("run_pwr_off_cfg", {31'd0, configu}, 32'd0);
      chk("run_pwr_off_mode", {29'd0, mode}, 32'd0);
      chk("run_pwr_off_timer", manualTimer, 32'd0);

      // Arbitration: Start and Mode debounce together in SELECT
      press(5'b00001);
      press(5'b00100);
      press(5'b00110);
      chk("arb_run", {31'd0, run}, 32'd1);
      chk("arb_mode", {29'd0, mode}, 32'd1);
      repeat (50) @(posedge clk); #1;
      pulse_cc();
      chk("arb_cc", {31'd0, run}, 32'd0);
      repeat (60) @(posedge clk); #1;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
      $finish;
   end

endmodule
